// File: rtl/uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : Byte-wide UART transmitter (8N1) with a small input FIFO.
//            Bytes written through data/wr_en are queued and shifted out on
//            Tx, LSB first, each bit held for DIV clock cycles. Frames are
//            sent back to back with no idle gap while the FIFO has data.
// Ports    : CLK      - system clock, rising-edge active
//            RST      - asynchronous active-high reset
//            data     - byte to enqueue
//            wr_en    - enqueue request (dropped when full)
//            full     - FIFO holds DEPTH bytes (registered)
//            busy     - frame in progress or FIFO non-empty
//            overflow - sticky, set when a write was dropped
//            Tx       - serial line, idle high (registered)
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int unsigned DIV   = 2604,
    parameter int unsigned DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] data,
    input  logic       wr_en,
    output logic       full,
    output logic       busy,
    output logic       overflow,
    output logic       Tx
);

    localparam int unsigned    AW        = $clog2(DEPTH);
    localparam int unsigned    CW        = AW + 1;
    localparam logic [15:0]    DIV_LAST  = 16'(DIV - 1);
    localparam logic [CW-1:0]  DEPTH_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          full_q;
    logic          overflow_q;

    // Transmit FSM
    state_t        state_q;
    state_t        state_d;
    logic [15:0]   div_cnt_q;
    logic [15:0]   div_cnt_d;
    logic [2:0]    bit_idx_q;
    logic [2:0]    bit_idx_d;
    logic [7:0]    shift_q;
    logic [7:0]    shift_d;
    logic          tx_q;
    logic          tx_d;

    logic          w_push;
    logic          w_pop;
    logic          w_fifo_empty;
    logic          w_div_wrap;
    logic [7:0]    w_head;

    // Fullness is judged on the registered (pre-edge) state, so a write that
    // coincides with a pop while full is still dropped.
    assign w_push       = wr_en & ~full_q;
    assign w_fifo_empty = (count_q == '0);
    assign w_head       = mem_q[rd_ptr_q];
    assign w_div_wrap   = (div_cnt_q == DIV_LAST);

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset; validity is tracked by the pointers/count.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            // Pointer widths are log2(DEPTH), so increments wrap modulo DEPTH.
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_CNT);
            if (wr_en && full_q) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        w_pop     = 1'b0;

        // Bit-period counter runs only while a frame is on the line and is
        // restarted from zero whenever a new frame begins.
        if (state_q != IDLE) begin
            div_cnt_d = w_div_wrap ? 16'd0 : div_cnt_q + 16'd1;
        end else begin
            div_cnt_d = 16'd0;
        end

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!w_fifo_empty) begin
                    w_pop   = 1'b1;
                    shift_d = w_head;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (w_div_wrap) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end
            end
            DATA: begin
                if (w_div_wrap) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (w_div_wrap) begin
                    if (!w_fifo_empty) begin
                        // Chain straight into the next frame with no idle gap.
                        w_pop   = 1'b1;
                        shift_d = w_head;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            div_cnt_q <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    assign Tx       = tx_q;
    assign full     = full_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE) || !w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Directed self-checking bench for uart_tx. One instance runs
//            with DIV=4/DEPTH=4 for framing, FIFO and reset scenarios; a
//            second instance uses the default DIV to measure bit length.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int DIV_T = 4;
    localparam int DIV_D = 2604;

    logic       CLK;
    logic       RST;
    logic [7:0] data;
    logic       wr_en;
    logic       full;
    logic       busy;
    logic       overflow;
    logic       Tx;

    logic [7:0] data2;
    logic       wr_en2;
    logic       full2;
    logic       busy2;
    logic       overflow2;
    logic       Tx2;

    int n_checks;
    int n_pass;

    uart_tx #(.DIV(DIV_T), .DEPTH(4)) u_dut (
        .CLK      (CLK),
        .RST      (RST),
        .data     (data),
        .wr_en    (wr_en),
        .full     (full),
        .busy     (busy),
        .overflow (overflow),
        .Tx       (Tx)
    );

    uart_tx u_dut_def (
        .CLK      (CLK),
        .RST      (RST),
        .data     (data2),
        .wr_en    (wr_en2),
        .full     (full2),
        .busy     (busy2),
        .overflow (overflow2),
        .Tx       (Tx2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Samples Tx once per cycle for frame cycles first..last (cycle 0 is the
    // first cycle of the start bit), advancing one negedge per sample.
    task automatic check_frame(input logic [7:0] b, input string tag, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            int   bp;
            logic e;
            bp = i / DIV_T;
            if (bp == 0)      e = 1'b0;
            else if (bp == 9) e = 1'b1;
            else              e = b[bp-1];
            chk($sformatf("%s_c%0d", tag, i), {31'd0, Tx}, {31'd0, e});
            @(negedge CLK);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        wr_en  = 1'b0;
        wr_en2 = 1'b0;
        RST    = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int lows;
        int highs;
        int t;
        int len;

        n_checks = 0;
        n_pass   = 0;
        RST      = 1'b1;
        data     = 8'h00;
        wr_en    = 1'b0;
        data2    = 8'h00;
        wr_en2   = 1'b0;

        // Reset state
        #1;
        chk("rst_tx",       {31'd0, Tx},        32'd1);
        chk("rst_busy",     {31'd0, busy},      32'd0);
        chk("rst_full",     {31'd0, full},      32'd0);
        chk("rst_ovf",      {31'd0, overflow},  32'd0);
        chk("rst_tx_def",   {31'd0, Tx2},       32'd1);
        chk("rst_busy_def", {31'd0, busy2},     32'd0);
        chk("rst_full_def", {31'd0, full2},     32'd0);
        chk("rst_ovf_def",  {31'd0, overflow2}, 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        // Single byte 0xA5 written on the first edge after reset release
        data  = 8'hA5;
        wr_en = 1'b1;
        @(negedge CLK);
        wr_en = 1'b0;
        chk("t1_tx_pre",   {31'd0, Tx},   32'd1);
        chk("t1_busy_pre", {31'd0, busy}, 32'd1);
        @(negedge CLK);
        check_frame(8'hA5, "t1", 0, 38);
        chk("t1_busy_stop", {31'd0, busy}, 32'd1);
        chk("t1_tx_stop",   {31'd0, Tx},   32'd1);
        @(negedge CLK);
        chk("t1_busy_end", {31'd0, busy}, 32'd0);
        chk("t1_tx_end",   {31'd0, Tx},   32'd1);

        // Data changes with wr_en low are ignored
        data = 8'hFF;
        @(negedge CLK);
        data = 8'h3C;
        @(negedge CLK);
        data = 8'h81;
        @(negedge CLK);
        chk("t0_busy", {31'd0, busy}, 32'd0);
        chk("t0_full", {31'd0, full}, 32'd0);
        chk("t0_tx",   {31'd0, Tx},   32'd1);

        // Back-to-back 0x00 then 0xFF
        data  = 8'h00;
        wr_en = 1'b1;
        @(negedge CLK);
        data  = 8'hFF;
        @(negedge CLK);
        wr_en = 1'b0;
        check_frame(8'h00, "t2a", 0, 39);
        check_frame(8'hFF, "t2b", 0, 39);
        chk("t2_busy_end", {31'd0, busy}, 32'd0);

        // Fill and overflow: 0x11 starts, 0x12..0x15 fill, 0x16 dropped
        for (int k = 0; k < 5; k++) begin
            data  = 8'(8'h11 + k);
            wr_en = 1'b1;
            @(negedge CLK);
        end
        chk("t3_full",    {31'd0, full},     32'd1);
        chk("t3_ovf_pre", {31'd0, overflow}, 32'd0);
        data = 8'h16;
        @(negedge CLK);
        wr_en = 1'b0;
        chk("t3_ovf",      {31'd0, overflow}, 32'd1);
        chk("t3_full_hold",{31'd0, full},     32'd1);
        check_frame(8'h11, "t3a", 4, 39);
        chk("t3_full_clr", {31'd0, full}, 32'd0);
        check_frame(8'h12, "t3b", 0, 39);
        check_frame(8'h13, "t3c", 0, 39);
        check_frame(8'h14, "t3d", 0, 39);
        check_frame(8'h15, "t3e", 0, 39);
        chk("t3_busy_end", {31'd0, busy}, 32'd0);
        chk("t3_ovf_stky", {31'd0, overflow}, 32'd1);

        // Write at full on the exact edge a frame ends and pops
        do_reset();
        chk("t4_ovf_rst", {31'd0, overflow}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            data  = 8'(8'h21 + k);
            wr_en = 1'b1;
            @(negedge CLK);
        end
        wr_en = 1'b0;
        chk("t4_full",    {31'd0, full},     32'd1);
        chk("t4_ovf_pre", {31'd0, overflow}, 32'd0);
        check_frame(8'h21, "t4a", 3, 38);
        chk("t4_tx_c39", {31'd0, Tx}, 32'd1);
        data  = 8'h26;
        wr_en = 1'b1;
        @(negedge CLK);
        wr_en = 1'b0;
        chk("t4_ovf",      {31'd0, overflow}, 32'd1);
        chk("t4_full_clr", {31'd0, full},     32'd0);
        check_frame(8'h22, "t4b", 0, 39);
        check_frame(8'h23, "t4c", 0, 39);
        check_frame(8'h24, "t4d", 0, 39);
        check_frame(8'h25, "t4e", 0, 39);
        lows = 0;
        for (int c = 0; c < 3 * DIV_T; c++) begin
            if (Tx !== 1'b1) lows++;
            @(negedge CLK);
        end
        chk("t4_no_extra", lows, 32'd0);
        chk("t4_busy_end", {31'd0, busy}, 32'd0);

        // Reset during data bit 3 of 0x3C with two bytes queued
        do_reset();
        data  = 8'h3C;
        wr_en = 1'b1;
        @(negedge CLK);
        data  = 8'hAA;
        @(negedge CLK);
        data  = 8'hBB;
        @(negedge CLK);
        wr_en = 1'b0;
        chk("t5_busy_pre", {31'd0, busy}, 32'd1);
        check_frame(8'h3C, "t5", 1, 17);
        RST = 1'b1;
        #1;
        chk("t5_tx_async",   {31'd0, Tx},       32'd1);
        chk("t5_busy_async", {31'd0, busy},     32'd0);
        chk("t5_full_async", {31'd0, full},     32'd0);
        chk("t5_ovf_async",  {31'd0, overflow}, 32'd0);
        repeat (2) @(negedge CLK);
        RST   = 1'b0;
        lows  = 0;
        highs = 0;
        for (int c = 0; c < 30 * DIV_T; c++) begin
            if (Tx !== 1'b1) lows++;
            if (busy !== 1'b0) highs++;
            @(negedge CLK);
        end
        chk("t5_tx_quiet",   lows,  32'd0);
        chk("t5_busy_quiet", highs, 32'd0);

        // Default DIV: 0x55 gives alternating bits, each 2604 cycles long
        data2  = 8'h55;
        wr_en2 = 1'b1;
        @(negedge CLK);
        wr_en2 = 1'b0;
        t = 0;
        while (Tx2 !== 1'b0 && t < 10) begin
            @(negedge CLK);
            t++;
        end
        chk("t6_latency", t, 32'd1);
        for (int s = 0; s < 9; s++) begin
            logic lvl;
            lvl = (s % 2 == 1);
            len = 0;
            while (Tx2 === lvl && len < 3000) begin
                len++;
                @(negedge CLK);
            end
            chk($sformatf("t6_bit%0d_len", s), len, DIV_D);
        end
        len = 0;
        while (Tx2 === 1'b1 && busy2 === 1'b1 && len < 3000) begin
            len++;
            @(negedge CLK);
        end
        chk("t6_stop_len",  len, DIV_D);
        chk("t6_busy_end",  {31'd0, busy2}, 32'd0);
        chk("t6_tx_end",    {31'd0, Tx2},   32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Parameters
REQ-001 SHALL have parameter DIV, default 2604, giving clock cycles per UART bit (9600 baud at 25 MHz); legal range 2..65535.
REQ-002 SHALL have parameter DEPTH, default 4, giving FIFO entries; power of two, 2..16.

Interface
REQ-003 SHALL have port CLK, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port data, input, 8 bits: byte to enqueue.
REQ-006 SHALL have port wr_en, input, 1 bit: enqueue request, sampled on the rising edge of CLK.
REQ-007 SHALL have port full, output, 1 bit: FIFO holds DEPTH bytes; registered.
REQ-008 SHALL have port busy, output, 1 bit: high when FSM is not IDLE or the FIFO is non-empty.
REQ-009 SHALL have port overflow, output, 1 bit: sticky flag, high once a write was dropped.
REQ-010 SHALL have port Tx, output, 1 bit: serial line, idle high; registered.

Function
REQ-011 SHALL frame each byte as 8N1: one start bit (0), data bits 0..7 LSB first, one stop bit (1), each held exactly DIV cycles (10*DIV cycles per frame).
REQ-012 SHALL enqueue data on an edge where wr_en=1 and full=0; the FIFO is first-in first-out, with no reordering or duplication.
REQ-013 SHALL drop the byte on an edge where wr_en=1 and full=1, set overflow=1, and leave FIFO contents unchanged.
REQ-014 SHALL use an FSM with states IDLE, START, DATA, STOP; in IDLE, Tx=1.
REQ-015 SHALL, in IDLE with the FIFO non-empty, pop the head into a shift register and enter START on the same edge; Tx=0 from that edge on.
REQ-016 Latency SHALL be as follows: a byte written at edge N into an empty FIFO while IDLE drives Tx=0 after edge N+1.
REQ-017 SHALL use a bit counter that counts 0..DIV-1 and wraps; the state or bit index advances only on wrap.
REQ-018 SHALL, in DATA, use a 3-bit index 0..7; after index 7 wraps, enter STOP.
REQ-019 SHALL, at the end of STOP, go directly to START with a pop if the FIFO is non-empty (zero idle cycles between frames), else go to IDLE.
REQ-020 SHALL, when a write and a pop occur on the same edge, update the FIFO count by net 0; full is judged on the pre-edge count, so a write at full is dropped even if a pop occurs on that edge.
REQ-021 SHALL use wrap-around read/write pointers modulo DEPTH and a count width of log2(DEPTH)+1 bits.
REQ-022 SHALL ignore data when wr_en=0.

Reset
REQ-023 SHALL, while RST=1, immediately and asynchronously force: Tx=1, FSM=IDLE, FIFO empty (pointers and count 0), full=0, busy=0, overflow=0, and counters 0.
REQ-024 SHALL abandon any frame in progress on reset mid-frame without completing its stop bit; the line returns high at once, and no queued byte is sent after release.
REQ-025 SHALL, after RST falls, accept writes from the first rising edge.

Verification (DIV=4, DEPTH=4 unless stated)
REQ-026 SHALL verify single byte: write 0xA5 at edge N -> Tx low after N+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles; busy falls after the stop bit; total 40 cycles.
REQ-027 SHALL verify back-to-back: write 0x00 then 0xFF on consecutive edges -> two frames with no idle cycle between the stop of the first and the start of the second; decoded 0x00, 0xFF.
REQ-028 SHALL verify fill/overflow: six consecutive writes 0x11..0x16 while the first frame starts -> 0x11 is popped, 0x12..0x15 are queued, full=1, 0x16 is dropped, overflow=1; line decodes 0x11..0x15 in order.
REQ-029 SHALL verify simultaneous write and pop: FIFO full, write issued on the exact edge a frame ends -> write dropped, overflow=1, count goes 4->3.
REQ-030 SHALL verify reset mid-frame: assert RST during DATA bit 3 of 0x3C with two bytes queued -> Tx=1 without waiting for a clock edge, busy=0, and no further frames after release.
REQ-031 SHALL verify default DIV=2604: one byte 0x55 -> each bit measured at exactly 2604 cycles.
